fetch_sequencer: RTL and testbench
==================================

// Module: fetch_sequencer
// PURPOSE
//  Owns the architectural PC and sequences instruction fetch over a req/ack imem port.
//  Holds each fetched word until the decode stage consumes it (!stall).
//  On consume, applies the decode stage's redirect (branch/j/jal/jr) via a next-PC calculator.
//  Sits between the instruction memory and the decode/control stage of the MIPS core.
// PARAMETERS
//  RESET_PC  32'h0000_3000  PC loaded on reset (first fetch address)
//  TIMEOUT   16             max cycles in REQ without imem_ack before fault (>=1)
// PORTS
//  clk            in   1   clock, all state on rising edge
//  rst_n          in   1   asynchronous, active-low reset
//  imem_req       out  1   fetch request; held high until imem_ack
//  imem_addr      out  32  fetch address (= pc_out while imem_req)
//  imem_ack       in   1   imem_rdata valid this cycle; completes request
//  imem_rdata     in   32  fetched instruction word
//  instr_valid    out  1   instr_out/pc_out hold an unconsumed instruction
//  instr_out      out  32  registered instruction
//  pc_out         out  32  PC of instr_out / current fetch
//  pc_plus_4      out  32  pc_out + 4 (for jal link)
//  stall          in   1   decode not ready; instruction not consumed
//  branch_taken   in   1   take branch, offset = signext(instr_out[15:0])<<2
//  jump           in   1   j/jal, target from instr_out[25:0]
//  jr             in   1   jump register
//  jr_target      in   32  register value for jr
//  fetch_err      out  1   sticky fault: imem timeout or misaligned target
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE, pc_out=RESET_PC, instr_out=0, all outputs 0
//   except pc_out/imem_addr=RESET_PC, pc_plus_4=RESET_PC+4; timeout counter=0.
//   Assertion mid-request drops imem_req immediately; an in-flight ack is discarded.
//  States: IDLE, REQ, VALID, FAULT (2-bit encoding).
//  IDLE : first edge after release -> REQ. No request issued.
//  REQ  : imem_req=1, imem_addr=pc_out. imem_ack -> latch imem_rdata into instr_out,
//         clear counter, -> VALID. Else counter++; counter==TIMEOUT-1 without ack
//         -> fetch_err=1, -> FAULT. Ack on the timeout cycle wins (no fault).
//  VALID: instr_valid=1, imem_req=0. stall=1 -> hold all state.
//         stall=0 (consume) -> pc_out<=NPC, -> REQ. Redirect inputs sampled only on consume;
//         ignored in all other states/cycles.
//  NPC priority: jr > jump > branch_taken > sequential.
//   seq    = pc_out+4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
//   branch = pc_out+4 + {{14{imm[15]}},imm,2'b00} (mod 2^32)
//   jump   = {pc_plus_4[31:28], instr_out[25:0], 2'b00}
//   jr     = jr_target
//  NPC[1:0]!=0 on consume -> fetch_err=1, -> FAULT, pc_out unchanged.
//  FAULT: terminal until reset; imem_req=0, instr_valid=0.
//  Latency: consume at edge N -> imem_req high in cycle N+1; best-case 2 cycles/instr.
// STRUCTURE
//  mips_pkg (shared): state localparams, RESET_PC default, opcode/field slice constants.
//  Sub-module npc_calc (combinational): pc, instr, branch_taken, jump, jr, jr_target
//   -> npc, pc_plus_4, misaligned. FSM, PC and instr registers, counter stay at top level.
// TESTING
//  Reset release: first imem_req with imem_addr=32'h3000; ack rdata=0 -> instr_valid next cycle.
//  Sequential: consume at PC 32'h3000, no redirect -> next imem_addr=32'h3004.
//  Branch: instr 32'h10220002 at 32'h3000, branch_taken=1 -> next imem_addr=32'h300C.
//  Jump: instr 32'h08000C04 at 32'h3004, jump=1 with branch_taken=1 -> imem_addr=32'h3010.
//  Stall: stall=1 for 5 cycles -> instr_out/pc_out stable, imem_req=0, no PC change.
//  Faults: no ack 16 cycles -> fetch_err=1, FAULT; jr_target=32'h3002 -> fetch_err=1;
//   rst_n pulse mid-REQ -> imem_req=0 immediately, refetch from 32'h3000.

Source files
------------

// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the fetch sequencer and its next-PC calculator.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_VALID = 2'd2,
        ST_FAULT = 2'd3
    } state_t;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam int          TIMEOUT_DEFAULT  = 16;

    // MIPS instruction field boundaries used by the redirect logic.
    localparam int IMM_MSB    = 15;
    localparam int TARGET_MSB = 25;
    localparam int OPCODE_LSB = 26;

    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch port between the fetch sequencer (master) and imem (slave).
interface fetch_sequencer_if;
    // imem_req rises when a fetch starts and stays high, with imem_addr stable, until the
    // first cycle imem_ack is high; imem_rdata is only meaningful in that ack cycle.
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack,
        input  imem_rdata
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack,
        output imem_rdata
    );
endinterface

// File: rtl/fetch_sequencer_npc_calc.sv
// Combinational next-PC calculator: sequential, branch, jump and jump-register targets,
// with priority jr > jump > branch > sequential, plus an alignment flag on the result.
module npc_calc
    import fetch_sequencer_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [31:0] instr,
    input  logic        branch_taken,
    input  logic        jump,
    input  logic        jr,
    input  logic [31:0] jr_target,
    output logic [31:0] npc,
    output logic [31:0] pc_plus_4,
    output logic        misaligned
);
    logic unused_opcode;

    // The opcode is decoded upstream; only the immediate and target fields matter here.
    assign unused_opcode = ^instr[31:OPCODE_LSB];

    assign pc_plus_4 = pc + 32'd4;

    always_comb begin
        npc = pc_plus_4;
        if (jr) begin
            npc = jr_target;
        end else if (jump) begin
            npc = {pc_plus_4[31:28], instr[TARGET_MSB:0], 2'b00};
        end else if (branch_taken) begin
            npc = pc_plus_4 + branch_offset(instr[IMM_MSB:0]);
        end
    end

    assign misaligned = |npc[1:0];

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches over the imem req/ack port, holds each word until
// decode consumes it, then steps or redirects the PC. Timeouts and bad targets are sticky.
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          TIMEOUT  = TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    fetch_sequencer_if.master imem,
    output logic              instr_valid,
    output logic [31:0]       instr_out,
    output logic [31:0]       pc_out,
    output logic [31:0]       pc_plus_4,
    input  logic              stall,
    input  logic              branch_taken,
    input  logic              jump,
    input  logic              jr,
    input  logic [31:0]       jr_target,
    output logic              fetch_err,
    output state_t            dbg_state
);
    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [31:0]      pc_q;
    logic [31:0]      instr_q;
    logic [CNT_W-1:0] cnt;
    logic             req_q;
    logic             valid_q;
    logic             err_q;
    logic [31:0]      npc;
    logic             misaligned;

    npc_calc u_npc_calc (
        .pc           (pc_q),
        .instr        (instr_q),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .npc          (npc),
        .pc_plus_4    (pc_plus_4),
        .misaligned   (misaligned)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            pc_q    <= RESET_PC;
            instr_q <= '0;
            cnt     <= '0;
            req_q   <= 1'b0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    state <= ST_REQ;
                    req_q <= 1'b1;
                end
                ST_REQ: begin
                    // An ack in the last allowed cycle still completes the fetch.
                    if (imem.imem_ack) begin
                        instr_q <= imem.imem_rdata;
                        cnt     <= '0;
                        req_q   <= 1'b0;
                        valid_q <= 1'b1;
                        state   <= ST_VALID;
                    end else if (cnt == CNT_LAST) begin
                        req_q <= 1'b0;
                        err_q <= 1'b1;
                        state <= ST_FAULT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                ST_VALID: begin
                    if (!stall) begin
                        valid_q <= 1'b0;
                        if (misaligned) begin
                            err_q <= 1'b1;
                            state <= ST_FAULT;
                        end else begin
                            pc_q  <= npc;
                            req_q <= 1'b1;
                            state <= ST_REQ;
                        end
                    end
                end
                default: begin
                    state <= ST_FAULT;
                end
            endcase
        end
    end

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = pc_q;
    assign instr_valid    = valid_q;
    assign instr_out      = instr_q;
    assign pc_out         = pc_q;
    assign fetch_err      = err_q;
    assign dbg_state      = state;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed boundary cases, then randomized fetch/consume traffic
// compared every cycle against a transaction-level reference model.
module tb_fetch_sequencer;
    import fetch_sequencer_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_3000;
    localparam int          TMO    = 16;

    // ---------------- clock / reset ----------------
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    logic        stall        = 1'b1;
    logic        branch_taken = 1'b0;
    logic        jump         = 1'b0;
    logic        jr           = 1'b0;
    logic [31:0] jr_target    = 32'h0;
    logic        instr_valid;
    logic        fetch_err;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic [31:0] pc_plus_4;
    state_t      dbg_state;

    fetch_sequencer_if imem_bus ();

    fetch_sequencer #(.RESET_PC(RST_PC), .TIMEOUT(TMO)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .imem         (imem_bus),
        .instr_valid  (instr_valid),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .pc_plus_4    (pc_plus_4),
        .stall        (stall),
        .branch_taken (branch_taken),
        .jump         (jump),
        .jr           (jr),
        .jr_target    (jr_target),
        .fetch_err    (fetch_err),
        .dbg_state    (dbg_state)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit check_en = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] m_pc       = RST_PC;
    logic [31:0] m_instr    = 32'h0;
    bit          m_boot     = 1'b1;
    bit          m_fetching = 1'b0;
    bit          m_holding  = 1'b0;
    bit          m_dead     = 1'b0;
    int          m_wait     = 0;
    logic [31:0] exp_q[$];

    function automatic logic [31:0] model_npc(input logic [31:0] pc, input logic [31:0] instr,
                                              input logic br, input logic jmp, input logic jrr,
                                              input logic [31:0] tgt);
        logic [31:0] seq;
        int          off;
        seq = pc + 32'd4;
        off = int'($signed(instr[15:0])) * 4;
        if (jrr) return tgt;
        if (jmp) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) << 2);
        if (br)  return seq + 32'(off);
        return seq;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        logic [31:0] n;
        if (!rst_n) begin
            m_pc = RST_PC; m_instr = 32'h0; m_wait = 0;
            m_boot = 1'b1; m_fetching = 1'b0; m_holding = 1'b0; m_dead = 1'b0;
            exp_q.delete();
            exp_q.push_back(RST_PC);
        end else if (m_dead) begin
            m_dead = 1'b1;
        end else if (m_boot) begin
            m_boot = 1'b0; m_fetching = 1'b1; m_wait = 0;
        end else if (m_fetching) begin
            if (imem_bus.imem_ack) begin
                m_instr = imem_bus.imem_rdata; m_fetching = 1'b0; m_holding = 1'b1; m_wait = 0;
            end else begin
                m_wait++;
                if (m_wait == TMO) begin
                    m_fetching = 1'b0; m_dead = 1'b1;
                end
            end
        end else if (m_holding && !stall) begin
            n = model_npc(m_pc, m_instr, branch_taken, jump, jr, jr_target);
            m_holding = 1'b0;
            if (n[1:0] != 2'b00) begin
                m_dead = 1'b1;
            end else begin
                m_pc = n; m_fetching = 1'b1; m_wait = 0;
                exp_q.push_back(n);
            end
        end
    end

    // ---------------- compare process ----------------
    bit prev_req = 1'b0;
    always @(negedge clk) begin
        if (check_en) begin
            check32("imem_req",    32'(imem_bus.imem_req), 32'(m_fetching));
            check32("instr_valid", 32'(instr_valid),       32'(m_holding));
            check32("fetch_err",   32'(fetch_err),         32'(m_dead));
            check32("pc_out",      pc_out,                 m_pc);
            check32("imem_addr",   imem_bus.imem_addr,     m_pc);
            check32("pc_plus_4",   pc_plus_4,              m_pc + 32'd4);
            check32("instr_out",   instr_out,              m_instr);
            if (imem_bus.imem_req && !prev_req) begin
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL fetch_order actual=%h expected=none", imem_bus.imem_addr);
                end else begin
                    check32("fetch_order", imem_bus.imem_addr, exp_q.pop_front());
                end
            end
        end
        prev_req = imem_bus.imem_req;
    end

    // ---------------- driver tasks ----------------
    task automatic drive_idle();
        stall = 1'b1; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0; jr_target = 32'h0;
        imem_bus.imem_ack = 1'b0; imem_bus.imem_rdata = 32'h0;
    endtask

    task automatic drive_junk(input bit allow_consume);
        stall        = allow_consume ? 1'($urandom_range(0, 1)) : 1'b1;
        branch_taken = 1'($urandom_range(0, 1));
        jump         = 1'($urandom_range(0, 1));
        jr           = 1'($urandom_range(0, 1));
        jr_target    = $urandom();
    endtask

    task automatic do_reset();
        @(negedge clk);
        #2 rst_n = 1'b0;
        drive_idle();
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
    endtask

    task automatic wait_req(output bit ok);
        ok = imem_bus.imem_req;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            ok = imem_bus.imem_req;
        end
        if (!ok) begin
            n_checks++; n_fail++;
            $display("FAIL wait_req actual=no_request expected=request_within_40_cycles");
        end
    endtask

    task automatic ack_word(input logic [31:0] w, input int delay, input bit junk);
        for (int k = 0; k < delay; k++) begin
            imem_bus.imem_ack = 1'b0;
            imem_bus.imem_rdata = $urandom();
            if (junk) drive_junk(1'b1);
            @(negedge clk);
        end
        imem_bus.imem_ack = 1'b1;
        imem_bus.imem_rdata = w;
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        imem_bus.imem_rdata = $urandom();
        stall = 1'b1; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    endtask

    task automatic hold(input int n);
        for (int k = 0; k < n; k++) begin
            drive_junk(1'b0);
            @(negedge clk);
        end
    endtask

    task automatic consume(input bit br, input bit jmp, input bit jrr, input logic [31:0] tgt);
        stall = 1'b0; branch_taken = br; jump = jmp; jr = jrr; jr_target = tgt;
        @(negedge clk);
        stall = 1'b1; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        bit          ok;
        int          d;
        bit          br, jmp, jrr;
        logic [31:0] tgt;

        drive_idle();
        do_reset();
        check_en = 1'b1;

        // Reset values before the first clock edge after release.
        check32("rst_pc_out",    pc_out,             32'h0000_3000);
        check32("rst_pc_plus_4", pc_plus_4,          32'h0000_3004);
        check32("rst_imem_req",  32'(imem_bus.imem_req), 32'h0);
        check32("rst_valid",     32'(instr_valid),   32'h0);
        check32("rst_err",       32'(fetch_err),     32'h0);
        check32("rst_instr",     instr_out,          32'h0);
        check32("rst_state",     32'(dbg_state),     32'(ST_IDLE));

        // First fetch, then sequential step.
        wait_req(ok);
        check32("first_addr", imem_bus.imem_addr, 32'h0000_3000);
        ack_word(32'h0, 0, 1'b0);
        check32("first_valid", 32'(instr_valid), 32'h1);
        consume(1'b0, 1'b0, 1'b0, 32'h0);
        check32("seq_req_next_cycle", 32'(imem_bus.imem_req), 32'h1);
        check32("seq_addr", imem_bus.imem_addr, 32'h0000_3004);

        // Jump beats a simultaneous branch.
        wait_req(ok);
        ack_word(32'h0800_0C04, 2, 1'b1);
        consume(1'b1, 1'b1, 1'b0, 32'h0);
        check32("jump_addr", imem_bus.imem_addr, 32'h0000_3010);

        // Taken branch with positive offset.
        do_reset();
        wait_req(ok);
        ack_word(32'h1022_0002, 0, 1'b0);
        consume(1'b1, 1'b0, 1'b0, 32'h0);
        check32("branch_addr", imem_bus.imem_addr, 32'h0000_300C);

        // Stall holds everything while redirect inputs toggle.
        wait_req(ok);
        ack_word(32'hDEAD_BEEF, 1, 1'b1);
        for (int k = 0; k < 5; k++) begin
            stall = 1'b1; jr = 1'b1; jr_target = 32'h0000_3002;
            branch_taken = 1'($urandom_range(0, 1)); jump = 1'($urandom_range(0, 1));
            @(negedge clk);
            check32("stall_instr", instr_out, 32'hDEAD_BEEF);
            check32("stall_pc",    pc_out,    32'h0000_300C);
            check32("stall_req",   32'(imem_bus.imem_req), 32'h0);
            check32("stall_valid", 32'(instr_valid), 32'h1);
        end

        // Misaligned jr target faults and leaves the PC alone.
        consume(1'b0, 1'b0, 1'b1, 32'h0000_3002);
        check32("misalign_err",   32'(fetch_err), 32'h1);
        check32("misalign_pc",    pc_out,         32'h0000_300C);
        check32("misalign_valid", 32'(instr_valid), 32'h0);
        consume(1'b0, 1'b0, 1'b0, 32'h0);
        hold(3);
        check32("fault_sticky_req", 32'(imem_bus.imem_req), 32'h0);
        check32("fault_sticky_err", 32'(fetch_err),          32'h1);

        // No ack for TIMEOUT cycles -> fault exactly on the last one.
        do_reset();
        wait_req(ok);
        for (int k = 1; k < TMO; k++) begin
            @(negedge clk);
            check32("tmo_not_yet", 32'(fetch_err), 32'h0);
        end
        @(negedge clk);
        check32("tmo_err", 32'(fetch_err), 32'h1);
        check32("tmo_req", 32'(imem_bus.imem_req), 32'h0);

        // Ack in the final allowed cycle wins over the timeout.
        do_reset();
        wait_req(ok);
        ack_word(32'h1234_5678, TMO - 1, 1'b0);
        check32("late_ack_valid", 32'(instr_valid), 32'h1);
        check32("late_ack_err",   32'(fetch_err),   32'h0);

        // PC wrap at the top of the address space.
        consume(1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC);
        check32("wrap_top_addr", imem_bus.imem_addr, 32'hFFFF_FFFC);
        check32("wrap_plus4",    pc_plus_4,          32'h0000_0000);
        wait_req(ok);
        ack_word(32'h0, 0, 1'b0);
        consume(1'b0, 1'b0, 1'b0, 32'h0);
        check32("wrap_zero_addr", imem_bus.imem_addr, 32'h0000_0000);

        // Reset pulse mid-request with an ack in flight.
        wait_req(ok);
        imem_bus.imem_ack = 1'b1; imem_bus.imem_rdata = 32'hCAFE_F00D;
        #2 rst_n = 1'b0;
        #1 check32("midreq_req_drop", 32'(imem_bus.imem_req), 32'h0);
        @(posedge clk);
        #1 check32("midreq_ack_dropped", instr_out, 32'h0);
        check32("midreq_pc", pc_out, 32'h0000_3000);
        @(negedge clk);
        imem_bus.imem_ack = 1'b0;
        #2 rst_n = 1'b1;
        wait_req(ok);
        check32("midreq_refetch", imem_bus.imem_addr, 32'h0000_3000);

        // Randomized traffic against the model.
        for (int it = 0; it < 250; it++) begin
            wait_req(ok);
            if (!ok) begin
                do_reset();
                continue;
            end
            if ($urandom_range(0, 39) == 0) begin
                for (int k = 0; k < TMO; k++) begin
                    imem_bus.imem_ack = 1'b0;
                    drive_junk(1'b1);
                    @(negedge clk);
                end
                do_reset();
                continue;
            end
            d = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TMO - 1) : $urandom_range(0, 2);
            ack_word($urandom(), d, 1'b1);
            hold($urandom_range(0, 3));
            br  = 1'($urandom_range(0, 1));
            jmp = ($urandom_range(0, 3) == 0);
            jrr = ($urandom_range(0, 7) == 0);
            tgt = $urandom() & 32'hFFFF_FFFC;
            if (jrr && $urandom_range(0, 3) == 0) tgt = tgt | 32'($urandom_range(1, 3));
            consume(br, jmp, jrr, tgt);
            if (m_dead) do_reset();
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running expected=finished");
        n_fail++;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "watchdog expired");
    end

endmodule
